pipelined_alu_stage: RTL

//  Parametrised, 2-stage pipelined successor of the single-cycle ALU in the execute stage.

---
 rtl/pipelined_alu_stage_if.sv | 28 ++
 rtl/pipelined_alu_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pipelined_alu_stage_if.sv
// Handshake bundle for the pipelined execute-stage ALU: operand channel in, result/flag channel out.
interface pipelined_alu_stage_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned OPW   = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [OPW-1:0]   operation;
   logic [WIDTH-1:0] readData0;
   logic [WIDTH-1:0] readData1;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             taken;
   logic             carry;
   logic             overflow;
   logic             illegal;

   modport master (
      output in_valid, operation, readData0, readData1, out_ready,
      input  in_ready, out_valid, result, taken, carry, overflow, illegal
   );

   modport slave (
      input  in_valid, operation, readData0, readData1, out_ready,
      output in_ready, out_valid, result, taken, carry, overflow, illegal
   );
endinterface

// File: rtl/pipelined_alu_stage.sv
// Two-stage pipelined execute ALU: S1 registers op+operands, S2 registers result and flags.
// Valid/ready on both sides; outputs stay bit-stable while the consumer stalls.
module pipelined_alu_stage #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned OPW   = 4
) (
   input logic                clk,
   input logic                rst,
   pipelined_alu_stage_if.slave bus
);
   localparam int unsigned MSB  = WIDTH - 1;
   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned SHW  = $clog2(WIDTH);

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_EVU = OPW'(2);
   localparam logic [OPW-1:0] OP_EVL = OPW'(3);
   localparam logic [OPW-1:0] OP_GTE = OPW'(4);
   localparam logic [OPW-1:0] OP_LTZ = OPW'(5);
   localparam logic [OPW-1:0] OP_EZ  = OPW'(6);
   localparam logic [OPW-1:0] OP_EQ  = OPW'(7);
   localparam logic [OPW-1:0] OP_NE  = OPW'(8);
   localparam logic [OPW-1:0] OP_AND = OPW'(9);
   localparam logic [OPW-1:0] OP_OR  = OPW'(10);
   localparam logic [OPW-1:0] OP_XOR = OPW'(11);
   localparam logic [OPW-1:0] OP_SRA = OPW'(12);

   logic             s1_valid;
   logic [OPW-1:0]   s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s2_ready;

   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             taken_q;
   logic             carry_q;
   logic             overflow_q;
   logic             illegal_q;

   logic [WIDTH:0]   sum_c;
   logic [WIDTH-1:0] diff_c;
   logic [WIDTH-1:0] res_c;
   logic             taken_c;
   logic             carry_c;
   logic             ovf_c;
   logic             ill_c;

   // Ready depends only on pipeline occupancy, never on in_valid.
   assign s2_ready     = !out_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_ready;

   // Stage 1: capture operation and operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_op <= bus.operation;
            s1_a  <= bus.readData0;
            s1_b  <= bus.readData1;
         end
      end
   end

   // Execute: every output gets a defined value for every op, illegal codes included.
   always_comb begin
      res_c   = '0;
      taken_c = 1'b0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      ill_c   = 1'b0;
      sum_c   = {1'b0, s1_a} + {1'b0, s1_b};
      diff_c  = s1_a - s1_b;
      case (s1_op)
         OP_ADD: begin
            res_c   = sum_c[WIDTH-1:0];
            carry_c = sum_c[WIDTH];
            ovf_c   = (s1_a[MSB] == s1_b[MSB]) && (sum_c[MSB] != s1_a[MSB]);
         end
         OP_SUB: begin
            res_c   = diff_c;
            carry_c = s1_a < s1_b;
            ovf_c   = (s1_a[MSB] != s1_b[MSB]) && (diff_c[MSB] != s1_a[MSB]);
         end
         OP_EVU:  res_c   = WIDTH'(~^s1_a[WIDTH-1:HALF]);
         OP_EVL:  res_c   = WIDTH'(~^s1_a[HALF-1:0]);
         OP_GTE:  taken_c = s1_a >= s1_b;
         OP_LTZ:  taken_c = s1_a[MSB];
         OP_EZ:   taken_c = s1_a == '0;
         OP_EQ:   taken_c = s1_a == s1_b;
         OP_NE:   taken_c = s1_a != s1_b;
         OP_AND:  res_c   = s1_a & s1_b;
         OP_OR:   res_c   = s1_a | s1_b;
         OP_XOR:  res_c   = s1_a ^ s1_b;
         OP_SRA:  res_c   = WIDTH'($signed(s1_a) >>> s1_b[SHW-1:0]);
         default: ill_c   = 1'b1;
      endcase
   end

   // Stage 2: register outputs; hold everything while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         taken_q     <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (s2_ready) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            result_q   <= res_c;
            taken_q    <= taken_c;
            carry_q    <= carry_c;
            overflow_q <= ovf_c;
            illegal_q  <= ill_c;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.taken     = taken_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.illegal   = illegal_q;
endmodule
